// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch / program counter for the basic processor. Each cycle it
// drives the instruction memory address. It supports absolute and PC-relative
// redirects, unconditional jumps, stalls, an explicit halt, restart from HALT,
// and an optional call/return stack.
//
// Optional feature macro: FETCH_RAS_EN
//   defined   : a circular return-address stack with RAS_DEPTH entries.
//               Call pushes PC+1 and Ret pops the stack. Overflow and
//               underflow each raise Ras_err for one cycle.
//   undefined : there is no stack. Call_en behaves like Jump_en, Ret_en is
//               ignored, and Ras_err is tied to 0.
//
// Parameters:
//   PC_W       program counter width
//   START_ADDR PC after reset and after restart
//   HALT_ADDR  fetching this address with no redirect ends the program
//   RAS_DEPTH  return-address stack entries (power of 2, >= 2)
//
// Ports:
//   CLK        clock, posedge
//   Init_n     asynchronous active-low reset
//   Start      restart request (honoured only in HALT)
//   Stall      hold PC this cycle (ignored in HALT)
//   Halt_req   explicit halt
//   Branch_en  conditional branch, taken when FLAG_IN = 1
//   FLAG_IN    branch condition
//   Jump_en    unconditional jump
//   Br_mode    0: Target is absolute, 1: Target is a signed offset from PC
//   Target     redirect target or offset
//   Call_en    call (push return address, then redirect)
//   Ret_en     return (pop into PC)
//   PC         current fetch address
//   Halt       high while in HALT
//   Ras_err    one-cycle stack overflow/underflow pulse
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned HALT_ADDR  = 36,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic            CLK,
  input  logic            Init_n,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Halt_req,
  input  logic            Branch_en,
  input  logic            FLAG_IN,
  input  logic            Jump_en,
  input  logic            Br_mode,
  input  logic [PC_W-1:0] Target,
  input  logic            Call_en,
  input  logic            Ret_en,
  output logic [PC_W-1:0] PC,
  output logic            Halt,
  output logic            Ras_err
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_HALT  = PC_W'(HALT_ADDR);
  // A HALT_ADDR wider than the PC can never be fetched, so the program then
  // runs (and wraps) forever.
  localparam bit HALT_IN_RANGE = ((HALT_ADDR >> PC_W) == 0);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] tgt;
  logic            at_halt_addr;

  assign pc_inc       = pc_q + PC_ONE;
  // In relative mode, modular addition applies the two's-complement offset.
  assign tgt          = Br_mode ? (pc_q + Target) : Target;
  assign at_halt_addr = HALT_IN_RANGE && (pc_q == PC_HALT);

`ifdef FETCH_RAS_EN
  localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = SP_W + 1;
  localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ras_err_q, ras_err_d;
  logic             push, pop;
  logic             ras_empty, ras_full;
  logic [PC_W-1:0]  ras_top;

  // sp_q points at the next free slot. Once the stack is full, that slot holds
  // the oldest entry, so a push there overwrites the oldest entry.
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);
  assign ras_top   = ras_mem[sp_q - SP_ONE];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_RAS_EN
    push      = 1'b0;
    pop       = 1'b0;
    ras_err_d = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (!Stall) begin
          if (Halt_req) begin
            state_d = ST_HALT;
`ifdef FETCH_RAS_EN
          end else if (Ret_en) begin
            // Ret takes priority over a simultaneous Call, which is dropped.
            if (ras_empty) begin
              pc_d      = pc_inc;
              ras_err_d = 1'b1;
            end else begin
              pc_d = ras_top;
              pop  = 1'b1;
            end
          end else if (Call_en) begin
            pc_d      = tgt;
            push      = 1'b1;
            ras_err_d = ras_full;
          end else if (Jump_en || (Branch_en && FLAG_IN)) begin
`else
          end else if (Call_en || Jump_en || (Branch_en && FLAG_IN)) begin
`endif
            pc_d = tgt;
          end else if (at_halt_addr) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_HALT: begin
        if (Start) begin
          pc_d    = PC_START;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      state_q <= ST_RUN;
      pc_q    <= PC_START;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_RAS_EN
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d = sp_q + SP_ONE;
      if (!ras_full) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (pop) begin
      sp_d  = sp_q - SP_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      sp_q      <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      ras_err_q <= ras_err_d;
    end
  end

  // The stack contents need no reset because the count marks the valid entries.
  always_ff @(posedge CLK) begin
    if (push) begin
      ras_mem[sp_q] <= pc_inc;
    end
  end

  assign Ras_err = ras_err_q;
`else
  logic unused_ret;
  assign unused_ret = Ret_en;
  assign Ras_err    = 1'b0;
`endif

  assign PC   = pc_q;
  assign Halt = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. The driver applies stimulus on the falling edge and
// steps a reference model. It queues the outputs expected after the next
// rising edge, and the monitor compares them against the DUT.
module tb_fetch_unit;

`ifdef FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int RAS_DEPTH = 4;
  localparam int HALT_A    = 36;
  localparam int PC_MOD    = 1024;

  logic       CLK = 1'b0;
  logic       Init_n, Start, Stall, Halt_req, Branch_en, FLAG_IN;
  logic       Jump_en, Br_mode, Call_en, Ret_en;
  logic [9:0] Target;
  logic [9:0] PC;
  logic       Halt, Ras_err;

  logic       rst_s_n;
  logic [3:0] PC_s;
  logic       Halt_s, Ras_err_s;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_W(10), .START_ADDR(0), .HALT_ADDR(36), .RAS_DEPTH(RAS_DEPTH)) dut (
    .CLK(CLK), .Init_n(Init_n), .Start(Start), .Stall(Stall), .Halt_req(Halt_req),
    .Branch_en(Branch_en), .FLAG_IN(FLAG_IN), .Jump_en(Jump_en), .Br_mode(Br_mode),
    .Target(Target), .Call_en(Call_en), .Ret_en(Ret_en),
    .PC(PC), .Halt(Halt), .Ras_err(Ras_err)
  );

  fetch_unit #(.PC_W(4), .START_ADDR(0), .HALT_ADDR(20), .RAS_DEPTH(4)) dut_small (
    .CLK(CLK), .Init_n(rst_s_n), .Start(1'b0), .Stall(1'b0), .Halt_req(1'b0),
    .Branch_en(1'b0), .FLAG_IN(1'b0), .Jump_en(1'b0), .Br_mode(1'b0),
    .Target(4'd0), .Call_en(1'b0), .Ret_en(1'b0),
    .PC(PC_s), .Halt(Halt_s), .Ras_err(Ras_err_s)
  );

  typedef struct {
    logic [9:0] pc;
    logic       halt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int m_pc;
  bit m_halt;
  bit m_err;
  int m_stack[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (PC !== mon_e.pc || Halt !== mon_e.halt || Ras_err !== mon_e.err) begin
        failures++;
        $display("FAIL out @%0t: PC=%0d Halt=%0b Ras_err=%0b expected PC=%0d Halt=%0b Ras_err=%0b",
                 $time, PC, Halt, Ras_err, mon_e.pc, mon_e.halt, mon_e.err);
      end
    end
  end

  function automatic void model_reset();
    m_pc   = 0;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_stack.delete();
  endfunction

  function automatic void model_step();
    int tgt;
    m_err = 1'b0;
    tgt   = Br_mode ? (m_pc + int'(Target)) % PC_MOD : int'(Target);
    if (m_halt) begin
      if (Start) begin
        m_pc   = 0;
        m_halt = 1'b0;
      end
    end else if (Stall) begin
      // hold everything
    end else if (Halt_req) begin
      m_halt = 1'b1;
    end else if (RAS_ON && Ret_en) begin
      if (m_stack.size() == 0) begin
        m_pc  = (m_pc + 1) % PC_MOD;
        m_err = 1'b1;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (Call_en) begin
      if (RAS_ON) begin
        if (m_stack.size() == RAS_DEPTH) begin
          m_stack.delete(0);
          m_err = 1'b1;
        end
        m_stack.push_back((m_pc + 1) % PC_MOD);
      end
      m_pc = tgt;
    end else if (Jump_en || (Branch_en && FLAG_IN)) begin
      m_pc = tgt;
    end else if (m_pc == HALT_A) begin
      m_halt = 1'b1;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endfunction

  task automatic clr();
    Start = 0; Stall = 0; Halt_req = 0; Branch_en = 0; FLAG_IN = 0;
    Jump_en = 0; Br_mode = 0; Call_en = 0; Ret_en = 0; Target = '0;
  endtask

  // Called just after a falling edge with the inputs already driven.
  task automatic cycle();
    exp_t e;
    model_step();
    e.pc   = 10'(m_pc);
    e.halt = m_halt;
    e.err  = m_err;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic run_to(input int addr);
    clr();
    for (int n = 0; n < 1100 && m_pc != addr; n++) cycle();
    if (m_pc != addr) begin
      failures++;
      $display("FAIL run_to: pc %0d never reached %0d", m_pc, addr);
    end
  endtask

  initial begin
    clr();
    Init_n  = 1'b0;
    rst_s_n = 1'b0;
    model_reset();
    #3;
    check("reset_pc", 32'(PC), 0);
    check("reset_halt", 32'(Halt), 0);
    check("reset_ras_err", 32'(Ras_err), 0);

    // Narrow PC with an unreachable halt address: it counts and wraps 15 -> 0.
    @(negedge CLK);
    rst_s_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      check("wrap_pc", 32'(PC_s), 32'(i % 16));
    end
    check("wrap_halt", 32'(Halt_s), 0);

    // Free run from reset up to the halt address.
    Init_n = 1'b1;
    for (int n = 0; n < 100 && !m_halt; n++) cycle();
    repeat (3) cycle();

    // Restart from HALT.
    Start = 1; cycle(); clr();

    // Relative branch taken and not taken at PC 5.
    run_to(5);
    Branch_en = 1; FLAG_IN = 1; Br_mode = 1; Target = 10'h3FE; cycle();
    run_to(5);
    Branch_en = 1; FLAG_IN = 0; Br_mode = 1; Target = 10'h3FE; cycle();

    // Stall with a jump pending, then release into an absolute jump.
    run_to(7);
    Stall = 1; Jump_en = 1; Target = 10'd20;
    repeat (3) cycle();
    Stall = 0; Br_mode = 0; cycle(); clr();

    // Halt_req is ignored under stall, then honoured at PC 12.
    Jump_en = 1; Target = 10'd10; cycle();
    run_to(11);
    Stall = 1; Halt_req = 1; cycle();
    run_to(12);
    Halt_req = 1; cycle(); clr();
    cycle();
    Jump_en = 1; Target = 10'd3; cycle(); clr();
    Start = 1; cycle(); clr();

    // A redirect at the halt address is taken, and the unit stays in RUN.
    run_to(HALT_A);
    Jump_en = 1; Target = 10'd3; cycle(); clr();
    cycle();

    // Call and return, nested overflow, and underflow.
    run_to(4);
    Call_en = 1; Target = 10'd30; cycle(); clr();
    Ret_en = 1; cycle(); clr();
    for (int k = 0; k < 5; k++) begin
      Call_en = 1; Target = 10'(100 + 10 * k); cycle();
    end
    clr(); cycle();
    for (int k = 0; k < 5; k++) begin
      Ret_en = 1; cycle();
    end
    clr();
    Call_en = 1; Target = 10'd200; cycle();
    Call_en = 1; Ret_en = 1; Target = 10'd300; cycle(); clr();
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      Stall     = ($urandom_range(0, 3) == 0);
      Halt_req  = ($urandom_range(0, 39) == 0);
      Branch_en = ($urandom_range(0, 5) == 0);
      FLAG_IN   = $urandom_range(0, 1) != 0;
      Jump_en   = ($urandom_range(0, 7) == 0);
      Call_en   = ($urandom_range(0, 7) == 0);
      Ret_en    = ($urandom_range(0, 7) == 0);
      Br_mode   = $urandom_range(0, 1) != 0;
      Target    = 10'($urandom);
      Start     = ($urandom_range(0, 2) == 0);
      cycle();
    end
    clr();

    // Asynchronous reset between clock edges while PC = 17.
    if (m_halt) begin
      Start = 1; cycle(); clr();
    end
    Jump_en = 1; Br_mode = 0; Target = 10'd15; cycle();
    run_to(17);
    check("pre_reset_pc", 32'(PC), 17);
    #2;
    Init_n = 1'b0;
    #1;
    check("async_reset_pc", 32'(PC), 0);
    check("async_reset_halt", 32'(Halt), 0);
    check("async_reset_ras_err", 32'(Ras_err), 0);
    model_reset();
    @(negedge CLK);
    Init_n = 1'b1;
    repeat (4) cycle();

    @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised next-generation instruction fetch / program counter for the basic processor.
- Generalised in PC width, start and halt addresses.
- Adds absolute/relative branching, unconditional jump, pipeline stall, explicit halt, restart, and an optional call/return stack.
- Drives the instruction memory address each cycle.

Parameters:
- PC_W, 10: program counter width in bits.
- START_ADDR, 0: PC value after reset and after restart.
- HALT_ADDR, 36: fetching this address with no redirect ends the program.
- RAS_DEPTH, 4: return-address stack entries (power of 2, ≥2); used only with FETCH_RAS_EN.

Ports:
- CLK  in  1: clock; all state changes on posedge.
- Init_n  in  1: asynchronous active-low reset.
- Start  in  1: restart request; honoured only in HALT.
- Stall  in  1: hold PC this cycle; ignored in HALT.
- Halt_req  in  1: explicit halt instruction.
- Branch_en  in  1: conditional branch instruction.
- FLAG_IN  in  1: branch condition; branch taken when Branch_en && FLAG_IN.
- Jump_en  in  1: unconditional jump.
- Br_mode  in  1: 0 = Target is absolute; 1 = Target is signed two's-complement offset from PC.
- Target  in  PC_W: branch/jump/call target or offset.
- Call_en  in  1: call (push return address, then jump).
- Ret_en  in  1: return (pop into PC).
- PC  out  PC_W: current fetch address.
- Halt  out  1: program done.
- Ras_err  out  1: one-cycle stack overflow/underflow pulse.

Behaviour:
- Reset (Init_n low, async):
  - PC = START_ADDR, Halt = 0, state = RUN, Ras_err = 0.
  - Stack pointer = 0, stack empty.
  - Reset may assert mid-operation; outputs update immediately, without waiting for a clock edge.
- States: RUN, HALT. Halt = 1 exactly when state is HALT.
- Redirect target (tgt):
  - Br_mode = 0: tgt = Target.
  - Br_mode = 1: tgt = PC + Target, modulo 2^PC_W.
- RUN with Stall = 1:
  - PC, state and stack hold.
  - All control inputs are ignored, including Halt_req.
- RUN with Stall = 0, first match wins:
  1. Halt_req: PC holds; go to HALT.
  2. Ret_en: PC <= popped address. If both Ret_en and Call_en are asserted, Ret wins and Call is dropped.
  3. Call_en: push PC+1; PC <= tgt.
  4. Jump_en: PC <= tgt.
  5. Branch_en && FLAG_IN: PC <= tgt.
  6. PC == HALT_ADDR: PC holds; go to HALT.
  7. Otherwise: PC <= PC + 1.
- A redirect issued while PC == HALT_ADDR is taken, and the unit stays in RUN.
- Branch_en with FLAG_IN = 0 falls through to rule 6/7.
- PC + 1 wraps from 2^PC_W−1 to 0.
- Latency: a redirect presented in cycle n appears on PC in cycle n+1. No delay slots.
- HALT:
  - PC and stack hold; all inputs are ignored except Start.
  - Start = 1: PC <= START_ADDR, go to RUN, Halt <= 0.
  - The stack is not cleared on restart.

Optional Feature:
- Macro FETCH_RAS_EN.
- Defined:
  - Circular return-address stack of RAS_DEPTH entries, PC_W bits each.
  - Push when full overwrites the oldest entry; Ras_err = 1 for one cycle; depth stays full.
  - Pop when empty: PC <= PC + 1; Ras_err = 1 for one cycle.
  - Ras_err is otherwise 0.
- Undefined:
  - No stack storage.
  - Call_en behaves exactly as Jump_en (no push).
  - Ret_en is ignored and falls through to the next rule.
  - Ras_err is tied to 0.
  - Port list is unchanged.

Test Plan:
- Reset then run free with defaults -> PC steps 0, 1, …, 36; Halt = 1 on the cycle after PC = 36; PC stays 36.
- At PC = 5: Branch_en = 1, FLAG_IN = 1, Br_mode = 1, Target = 10'h3FE (−2) -> PC = 3 next cycle. Repeat with FLAG_IN = 0 -> PC = 6.
- At PC = 7: Stall = 1 for 3 cycles with Jump_en = 1 -> PC stays 7. Release Stall with Jump_en = 1, Br_mode = 0, Target = 20 -> PC = 20.
- FETCH_RAS_EN defined: call at PC = 4 to 30, then Ret at 30 -> PC 30, then 5. Five nested calls with RAS_DEPTH = 4 -> Ras_err pulses on the 5th call. Ret on empty stack -> PC + 1 and Ras_err pulse.
- In HALT: Start = 1 -> PC = START_ADDR, Halt = 0 next cycle. Halt_req at PC = 12 -> HALT with PC = 12.
- Assert Init_n = 0 between clock edges while PC = 17 -> PC = 0, Halt = 0 immediately. PC_W = 4 free-run with HALT_ADDR = 20 (never reached) -> PC wraps 15 -> 0.
